execute_stage: RTL and testbench

- Execute stage directly upstream of the memory/write-back stage.
- Accepts one decoded instruction (operands, ALU opcode, control flags), computes the ALU result, and registers it into an EX/MEM output register.
- Those registered outputs drive the memory/write-back stage's reg_we, is_load, is_store, is_halt, dstreg_num, op1, op2 and alu_result inputs.
- Multiply is optional and multi-cycle (radix-2 shift-add); it stalls the decoder through in_ready.

---
 rtl/execute_stage.sv | 219 +++++++++++++++++++++
 tb/tb_execute_stage.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// execute_stage: ALU execute stage feeding the EX/MEM register.
// Optional multiply (radix-2 shift-add, multi-cycle) is built when the
// EXEC_MUL_EN macro is defined. Otherwise MUL behaves as a reserved opcode.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | accepting one instruction per cycle (unless flushing)
// MUL_BUSY | shift-add multiply iterating, decoder stalled
// HALTED   | halt has retired; only reset leaves this state
module execute_stage #(
   parameter int XLEN       = 32,
   parameter int MUL_CYCLES = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_op,
   input  logic [XLEN-1:0] in_op1,
   input  logic [XLEN-1:0] in_op2,
   input  logic            in_reg_we,
   input  logic            in_is_load,
   input  logic            in_is_store,
   input  logic            in_is_halt,
   input  logic [4:0]      in_dstreg_num,
   output logic            out_valid,
   output logic            reg_we,
   output logic            is_load,
   output logic            is_store,
   output logic            is_halt,
   output logic [4:0]      dstreg_num,
   output logic [XLEN-1:0] op1,
   output logic [XLEN-1:0] op2,
   output logic [XLEN-1:0] alu_result,
   output logic            busy,
   output logic            halted
);

   typedef enum logic [1:0] {IDLE, MUL_BUSY, HALTED} state_t;

   localparam logic [3:0] OP_MUL = 4'd11;

   state_t          state, next_state;
   logic            accept;
   logic            load_ex;
   logic [4:0]      shamt;
   logic [XLEN-1:0] alu_value;

`ifdef EXEC_MUL_EN
   localparam int CW = $clog2(MUL_CYCLES);

   logic [XLEN-1:0] mul_mcand, mul_mplier, mul_acc, mul_sum;
   logic [XLEN-1:0] pend_op1, pend_op2;
   logic [CW-1:0]   mul_cnt;
   logic [4:0]      pend_dst;
   logic            pend_we, pend_ld, pend_st, pend_hl;
   logic            mul_start, mul_step, mul_done;

   // partial product accumulated on each iteration (low XLEN bits only)
   assign mul_sum = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
`endif

   assign accept = in_valid & in_ready;

   // single-cycle ALU on the presented operands
   always_comb begin
      alu_value = '0;
      shamt     = in_op2[4:0];
      case (alu_op)
         4'd0:  alu_value = in_op1 + in_op2;
         4'd1:  alu_value = in_op1 - in_op2;
         4'd2:  alu_value = in_op1 & in_op2;
         4'd3:  alu_value = in_op1 | in_op2;
         4'd4:  alu_value = in_op1 ^ in_op2;
         4'd5:  alu_value = in_op1 << shamt;
         4'd6:  alu_value = in_op1 >> shamt;
         4'd7:  alu_value = XLEN'($signed(in_op1) >>> shamt);
         4'd8:  alu_value = {{(XLEN-1){1'b0}}, $signed(in_op1) < $signed(in_op2)};
         4'd9:  alu_value = {{(XLEN-1){1'b0}}, in_op1 < in_op2};
         4'd10: alu_value = in_op2;
         default: alu_value = '0;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // next-state and handshake decode
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      busy       = 1'b0;
      halted     = 1'b0;
      load_ex    = 1'b0;
`ifdef EXEC_MUL_EN
      mul_start  = 1'b0;
      mul_step   = 1'b0;
      mul_done   = 1'b0;
`endif
      case (state)
         IDLE: begin
            in_ready = ~flush;
            if (accept) begin
`ifdef EXEC_MUL_EN
               if (alu_op == OP_MUL) begin
                  mul_start  = 1'b1;
                  next_state = MUL_BUSY;
               end else begin
                  load_ex = 1'b1;
                  if (in_is_halt) next_state = HALTED;
               end
`else
               load_ex = 1'b1;
               if (in_is_halt) next_state = HALTED;
`endif
            end
         end
`ifdef EXEC_MUL_EN
         MUL_BUSY: begin
            busy = 1'b1;
            if (flush) begin
               next_state = IDLE;
            end else begin
               mul_step = 1'b1;
               if (mul_cnt == '0) begin
                  mul_done   = 1'b1;
                  next_state = pend_hl ? HALTED : IDLE;
               end
            end
         end
`endif
         HALTED: halted = 1'b1;
         default: next_state = IDLE;
      endcase
   end

   // EX/MEM register and multiplier datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         reg_we     <= 1'b0;
         is_load    <= 1'b0;
         is_store   <= 1'b0;
         is_halt    <= 1'b0;
         dstreg_num <= '0;
         op1        <= '0;
         op2        <= '0;
         alu_result <= '0;
`ifdef EXEC_MUL_EN
         mul_mcand  <= '0;
         mul_mplier <= '0;
         mul_acc    <= '0;
         mul_cnt    <= '0;
         pend_op1   <= '0;
         pend_op2   <= '0;
         pend_dst   <= '0;
         pend_we    <= 1'b0;
         pend_ld    <= 1'b0;
         pend_st    <= 1'b0;
         pend_hl    <= 1'b0;
`endif
      end else begin
         // control is a per-cycle pulse; data fields hold between loads
         out_valid <= 1'b0;
         reg_we    <= 1'b0;
         is_load   <= 1'b0;
         is_store  <= 1'b0;
         is_halt   <= 1'b0;
         if (load_ex) begin
            out_valid  <= 1'b1;
            reg_we     <= in_reg_we;
            is_load    <= in_is_load;
            is_store   <= in_is_store;
            is_halt    <= in_is_halt;
            dstreg_num <= in_dstreg_num;
            op1        <= in_op1;
            op2        <= in_op2;
            alu_result <= alu_value;
         end
`ifdef EXEC_MUL_EN
         if (mul_start) begin
            mul_mcand  <= in_op1;
            mul_mplier <= in_op2;
            mul_acc    <= '0;
            mul_cnt    <= CW'(MUL_CYCLES - 1);
            pend_op1   <= in_op1;
            pend_op2   <= in_op2;
            pend_dst   <= in_dstreg_num;
            pend_we    <= in_reg_we;
            pend_ld    <= in_is_load;
            pend_st    <= in_is_store;
            pend_hl    <= in_is_halt;
         end
         if (mul_step) begin
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            mul_acc    <= mul_sum;
            mul_cnt    <= mul_cnt - 1'b1;
         end
         if (mul_done) begin
            out_valid  <= 1'b1;
            reg_we     <= pend_we;
            is_load    <= pend_ld;
            is_store   <= pend_st;
            is_halt    <= pend_hl;
            dstreg_num <= pend_dst;
            op1        <= pend_op1;
            op2        <= pend_op2;
            alu_result <= mul_sum;
         end
`endif
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed scenarios plus randomized single-cycle
// traffic compared against an arithmetic reference model.
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush, in_valid, in_ready;
   logic [3:0]  alu_op;
   logic [31:0] in_op1, in_op2;
   logic        in_reg_we, in_is_load, in_is_store, in_is_halt;
   logic [4:0]  in_dstreg_num;
   logic        out_valid, reg_we, is_load, is_store, is_halt;
   logic [4:0]  dstreg_num;
   logic [31:0] op1, op2, alu_result;
   logic        busy, halted;

   int checks = 0;
   int errors = 0;

   // reference EX/MEM contents
   logic        e_valid, e_we, e_ld, e_st, e_hl;
   logic [4:0]  e_dst;
   logic [31:0] e_op1, e_op2, e_res;

   execute_stage dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
      .in_ready(in_ready), .alu_op(alu_op), .in_op1(in_op1), .in_op2(in_op2),
      .in_reg_we(in_reg_we), .in_is_load(in_is_load), .in_is_store(in_is_store),
      .in_is_halt(in_is_halt), .in_dstreg_num(in_dstreg_num),
      .out_valid(out_valid), .reg_we(reg_we), .is_load(is_load),
      .is_store(is_store), .is_halt(is_halt), .dstreg_num(dstreg_num),
      .op1(op1), .op2(op2), .alu_result(alu_result), .busy(busy), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic fl, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic we, input logic ld, input logic st,
                        input logic hl, input logic [4:0] dst);
      in_valid = v; flush = fl; alu_op = op; in_op1 = a; in_op2 = b;
      in_reg_we = we; in_is_load = ld; in_is_store = st; in_is_halt = hl;
      in_dstreg_num = dst;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ov"},  32'(out_valid), 32'd0);
      chk({tag, "_ctl"}, {28'd0, reg_we, is_load, is_store, is_halt}, 32'd0);
      chk({tag, "_dst"}, 32'(dstreg_num), 32'd0);
      chk({tag, "_op1"}, op1, 32'd0);
      chk({tag, "_op2"}, op2, 32'd0);
      chk({tag, "_res"}, alu_result, 32'd0);
      chk({tag, "_bh"},  {30'd0, busy, halted}, 32'd0);
   endtask

   // arithmetic meaning of each opcode
   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      int unsigned ua = a, ub = b, sh = b % 32;
      int          sa = a, sb = b;
      longint unsigned prod;
      case (op)
         4'd0:  return 32'(ua + ub);
         4'd1:  return 32'(ua - ub);
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return a ^ b;
         4'd5:  return 32'(longint'(ua) * (longint'(1) << sh));
         4'd6:  return 32'(ua / (32'd1 << sh));
         4'd7:  return 32'(sa >>> sh);
         4'd8:  return (sa < sb) ? 32'd1 : 32'd0;
         4'd9:  return (ua < ub) ? 32'd1 : 32'd0;
         4'd10: return b;
         4'd11: begin
`ifdef EXEC_MUL_EN
            prod = longint'(ua) * longint'(ub);
            return prod[31:0];
`else
            prod = 0;
            return prod[31:0];
`endif
         end
         default: return 32'd0;
      endcase
   endfunction

   task automatic chk_model(input string tag);
      chk({tag, "_ov"},  32'(out_valid), 32'(e_valid));
      chk({tag, "_ctl"}, {28'd0, reg_we, is_load, is_store, is_halt},
          {28'd0, e_we, e_ld, e_st, e_hl});
      chk({tag, "_dst"}, 32'(dstreg_num), 32'(e_dst));
      chk({tag, "_op1"}, op1, e_op1);
      chk({tag, "_op2"}, op2, e_op2);
      chk({tag, "_res"}, alu_result, e_res);
   endtask

   initial begin
      logic       v, fl;
      logic [3:0] op;

      // ---------------- reset ----------------
      rst_n = 1'b0;
      idle();
      #2;
      chk_all_zero("reset");
      chk("reset_ready", 32'(in_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // ---------------- ADD ----------------
      drive(1'b1, 1'b0, 4'd0, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3);
      tick();
      idle();
      chk("add_ov", 32'(out_valid), 32'd1);
      chk("add_res", alu_result, 32'd12);
      chk("add_we", 32'(reg_we), 32'd1);
      chk("add_dst", 32'(dstreg_num), 32'd3);
      tick();
      chk("add_idle_ov", 32'(out_valid), 32'd0);
      chk("add_idle_we", 32'(reg_we), 32'd0);
      chk("add_idle_res_hold", alu_result, 32'd12);

      // ---------------- SRA / SLT / SLTU back-to-back ----------------
      drive(1'b1, 1'b0, 4'd7, 32'h8000_0000, 32'd4, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1);
      #1 chk("sra_ready", 32'(in_ready), 32'd1);
      tick();
      chk("sra_res", alu_result, 32'hF800_0000);
      drive(1'b1, 1'b0, 4'd8, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2);
      #1 chk("slt_ready", 32'(in_ready), 32'd1);
      tick();
      chk("slt_res", alu_result, 32'd1);
      chk("slt_ov", 32'(out_valid), 32'd1);
      drive(1'b1, 1'b0, 4'd9, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4);
      #1 chk("sltu_ready", 32'(in_ready), 32'd1);
      tick();
      chk("sltu_res", alu_result, 32'd0);
      chk("sltu_ov", 32'(out_valid), 32'd1);
      idle();
      tick();

      // ---------------- MUL ----------------
      drive(1'b1, 1'b0, 4'd11, 32'h0001_0003, 32'd5, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7);
      tick();
      idle();
`ifdef EXEC_MUL_EN
      for (int i = 1; i <= 32; i++) begin
         chk($sformatf("mul_busy_c%0d", i), {29'd0, in_ready, busy, out_valid}, 32'b010);
         tick();
      end
      chk("mul_res", alu_result, 32'h0005_000F);
      chk("mul_ov", 32'(out_valid), 32'd1);
      chk("mul_dst", 32'(dstreg_num), 32'd7);
      chk("mul_done_ready", {30'd0, in_ready, busy}, 32'b10);
      tick();

      // flush on the 10th busy cycle
      drive(1'b1, 1'b0, 4'd11, 32'd9, 32'd9, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8);
      tick();
      idle();
      for (int i = 1; i < 10; i++) tick();
      chk("flush_busy10", 32'(busy), 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1 chk("flush_ready_after", 32'(in_ready), 32'd1);
      chk("flush_busy_after", 32'(busy), 32'd0);
      begin
         int seen = 0;
         for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            tick();
         end
         chk("flush_no_ov", 32'(seen), 32'd0);
      end
      drive(1'b1, 1'b0, 4'd0, 32'd20, 32'd22, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9);
      tick();
      idle();
      chk("flush_add_res", alu_result, 32'd42);
      chk("flush_add_ov", 32'(out_valid), 32'd1);
`else
      chk("mul_res", alu_result, 32'd0);
      chk("mul_ov", 32'(out_valid), 32'd1);
      chk("mul_we", 32'(reg_we), 32'd1);
      chk("mul_busy", 32'(busy), 32'd0);
`endif
      tick();

      // ---------------- randomized single-cycle traffic ----------------
      e_valid = 1'b0; e_we = 1'b0; e_ld = 1'b0; e_st = 1'b0; e_hl = 1'b0;
      e_dst = '0; e_op1 = '0; e_op2 = '0; e_res = '0;
      for (int i = 0; i < 300; i++) begin
         v  = (i == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
         fl = (i == 0) ? 1'b0 : 1'($urandom_range(0, 7) == 0);
         op = 4'($urandom_range(0, 15));
`ifdef EXEC_MUL_EN
         if (op == 4'd11) op = 4'd1;
`endif
         drive(v, fl, op, $urandom, (i % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom,
               1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 5'($urandom));
         #1 chk("rnd_ready", 32'(in_ready), 32'(!fl));
         if (v && !fl) begin
            e_valid = 1'b1; e_we = in_reg_we; e_ld = in_is_load; e_st = in_is_store;
            e_hl = 1'b0; e_dst = in_dstreg_num; e_op1 = in_op1; e_op2 = in_op2;
            e_res = ref_alu(op, in_op1, in_op2);
         end else begin
            e_valid = 1'b0; e_we = 1'b0; e_ld = 1'b0; e_st = 1'b0; e_hl = 1'b0;
         end
         tick();
         chk_model($sformatf("rnd%0d_op%0d", i, op));
      end
      idle();
      tick();

      // ---------------- store then halt ----------------
      drive(1'b1, 1'b0, 4'd0, 32'h100, 32'hDEAD, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
      tick();
      chk("store_st", 32'(is_store), 32'd1);
      chk("store_op2", op2, 32'hDEAD);
      chk("store_addr", alu_result, 32'hDFAD);
      drive(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
      tick();
      idle();
      chk("halt_pulse", {29'd0, is_halt, out_valid, halted}, 32'b111);
      chk("halt_ready", 32'(in_ready), 32'd0);
      tick();
      chk("halt_pulse_end", {29'd0, is_halt, out_valid, halted}, 32'b001);
      begin
         int bad = 0;
         for (int i = 0; i < 100; i++) begin
            in_valid = 1'(i % 2);
            flush    = 1'(i % 3 == 0);
            #1;
            if (in_ready !== 1'b0) bad++;
            tick();
            if (halted !== 1'b1 || out_valid !== 1'b0) bad++;
         end
         chk("halt_hold_100", 32'(bad), 32'd0);
      end
      idle();

      // ---------------- async reset mid-halt ----------------
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk_all_zero("rst_halt");
      chk("rst_halt_ready", 32'(in_ready), 32'd1);
      tick();
      rst_n = 1'b1;

      // ---------------- async reset mid-operation ----------------
`ifdef EXEC_MUL_EN
      drive(1'b1, 1'b0, 4'd11, 32'd3, 32'd3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5);
      tick();
      idle();
      repeat (5) tick();
      chk("pre_rst_busy", 32'(busy), 32'd1);
`else
      drive(1'b1, 1'b0, 4'd0, 32'd3, 32'd3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5);
      tick();
      idle();
      chk("pre_rst_ov", 32'(out_valid), 32'd1);
`endif
      #2 rst_n = 1'b0;
      #1 chk_all_zero("rst_mid");
      tick();
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 4'd0, 32'd1, 32'd1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1);
      tick();
      idle();
      chk("post_rst_add", alu_result, 32'd2);
      chk("post_rst_ov", 32'(out_valid), 32'd1);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // hard time limit so the run always ends
   initial begin
      #500000;
      errors++;
      $display("FAIL timeout observed=running expected=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
